// File: rtl/multicycle_adder.sv
// multicycle_adder: WIDTH-bit ripple adder, SLICE bits per cycle.
// Optional subtract mode enabled by defining MCADD_SUB_EN.
module multicycle_adder #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
`ifdef MCADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  localparam int NS = WIDTH / SLICE;
  localparam int KW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NS - 1);

  generate
    if ((WIDTH % SLICE) != 0 || SLICE < 1) begin : g_bad_cfg
      $error("multicycle_adder: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic             carry_q;
  logic [KW-1:0]    k;
  logic [SLICE:0]   slice_sum;
  logic             last;
  logic             take;
  logic [WIDTH-1:0] b_in;
  logic             c_in;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign take      = in_valid & in_ready;
  assign last      = (k == K_LAST);

`ifdef MCADD_SUB_EN
  // subtraction is a + ~b + ~borrow
  assign b_in = sub ? ~b : b;
  assign c_in = sub ? ~ci : ci;
`else
  assign b_in = b;
  assign c_in = ci;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (take)      state_nxt = BUSY;
      BUSY:    if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // add the current slice with the held carry
  always_comb begin
    slice_sum = {1'b0, a_q[int'(k)*SLICE +: SLICE]}
              + {1'b0, b_q[int'(k)*SLICE +: SLICE]}
              + {{SLICE{1'b0}}, carry_q};
    acc_nxt = acc;
    acc_nxt[int'(k)*SLICE +: SLICE] = slice_sum[SLICE-1:0];
  end

  // operand capture and slice-by-slice accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      carry_q <= 1'b0;
      k       <= '0;
    end else if (state == IDLE) begin
      if (take) begin
        a_q     <= a;
        b_q     <= b_in;
        carry_q <= c_in;
        k       <= '0;
      end
    end else if (state == BUSY) begin
      acc     <= acc_nxt;
      carry_q <= slice_sum[SLICE];
      k       <= last ? '0 : k + KW'(1);
    end
  end

  // result registers load only when entering DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
      co  <= 1'b0;
    end else if (state == BUSY && last) begin
      sum <= acc_nxt;
      co  <= slice_sum[SLICE];
    end
  end

endmodule

// File: tb/tb_multicycle_adder.sv
// tb_multicycle_adder: directed checks of the multi-cycle adder.
// Covers default slicing and the single-slice build.
module tb_multicycle_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        ci = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] sum;
  logic        co;
`ifdef MCADD_SUB_EN
  logic        sub = 1'b0;
  logic        sub8 = 1'b0;
`endif

  logic        in_valid8 = 1'b0;
  logic        in_ready8;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        ci8 = 1'b0;
  logic        out_valid8;
  logic        out_ready8 = 1'b1;
  logic [7:0]  sum8;
  logic        co8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multicycle_adder #(.WIDTH(32), .SLICE(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci),
`ifdef MCADD_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .co(co)
  );

  multicycle_adder #(.WIDTH(8), .SLICE(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .ci(ci8),
`ifdef MCADD_SUB_EN
    .sub(sub8),
`endif
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .co(co8)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one full transaction with out_ready held high
  task automatic run_op(input string tag,
                        input logic [31:0] av,
                        input logic [31:0] bv,
                        input logic cv,
                        input logic sv,
                        input logic [31:0] es,
                        input logic ec);
    int n;
    logic rdy_bad;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, in_ready, 1'b1);
    out_ready = 1'b1;
    a = av; b = bv; ci = cv;
`ifdef MCADD_SUB_EN
    sub = sv;
`else
    if (sv) $display("note: sub requested without MCADD_SUB_EN");
`endif
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    rdy_bad = 1'b0;
    while (!out_valid && n < 20) begin
      if (in_ready) rdy_bad = 1'b1;
      tick();
      n++;
    end
    if (in_ready) rdy_bad = 1'b1;
    check({tag, "_lat"}, n, 4);
    check({tag, "_rdy_low"}, rdy_bad, 1'b0);
    check({tag, "_sum"}, sum, es);
    check({tag, "_co"}, co, ec);
    tick();
    check({tag, "_rdy_back"}, in_ready, 1'b1);
    check({tag, "_ov_drop"}, out_valid, 1'b0);
  endtask

  initial begin
    int n;
    logic hold_bad;
    #12;
    check("rst_ready", in_ready, 1'b1);
    check("rst_ovalid", out_valid, 1'b0);
    check("rst_sum", sum, 32'h0);
    check("rst_co", co, 1'b0);
    rst_n = 1'b1;
    tick();

    run_op("ripple", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0,
           32'h0000_0000, 1'b1);
    run_op("mixed", 32'h1234_5678, 32'h0FED_CBA8, 1'b0, 1'b0,
           32'h2222_2220, 1'b0);

    // backpressure with ignored input pulses
    out_ready = 1'b0;
    a = 32'h8000_0000; b = 32'h8000_0001; ci = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("bp_lat", n, 4);
    hold_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      a = 32'hDEAD_0000 + i; b = 32'h1111; ci = 1'b1;
      in_valid = i[0];
      tick();
      if (!out_valid || in_ready || sum !== 32'h1 || co !== 1'b1)
        hold_bad = 1'b1;
    end
    in_valid = 1'b0;
    check("bp_hold", hold_bad, 1'b0);
    check("bp_sum", sum, 32'h0000_0001);
    check("bp_co", co, 1'b1);
    out_ready = 1'b1;
    tick();
    check("bp_release", out_valid, 1'b0);
    tick();
    check("bp_no_accept", in_ready, 1'b1);
    check("bp_sum_kept", sum, 32'h0000_0001);

    // reset two cycles after accept
    a = 32'h0000_00FF; b = 32'h0000_0001; ci = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mrst_ready", in_ready, 1'b1);
    check("mrst_ovalid", out_valid, 1'b0);
    check("mrst_sum", sum, 32'h0);
    check("mrst_co", co, 1'b0);
    #3;
    rst_n = 1'b1;
    tick();
    run_op("post_rst", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0,
           32'h0000_0100, 1'b0);

`ifdef MCADD_SUB_EN
    run_op("sub_neg", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    run_op("sub_pos", 32'd7, 32'd5, 1'b0, 1'b1, 32'h0000_0002, 1'b1);
    run_op("sub_off", 32'd7, 32'd5, 1'b0, 1'b0, 32'h0000_000C, 1'b0);
`endif

    // single-slice instance
    a8 = 8'h80; b8 = 8'h80; ci8 = 1'b1;
    in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    check("deg_busy", in_ready8, 1'b0);
    n = 0;
    while (!out_valid8 && n < 20) begin
      tick();
      n++;
    end
    check("deg_lat", n, 1);
    check("deg_sum", sum8, 8'h01);
    check("deg_co", co8, 1'b1);
    tick();
    check("deg_ready", in_ready8, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_adder.md
# multicycle_adder

Parametrised multi-cycle ripple adder that computes a WIDTH-bit sum with carry-in and carry-out. Each cycle it adds one SLICE-bit slice and keeps the carry in a register between slices. Operands enter and results leave through valid/ready handshakes, so the block can sit between pipeline stages in arithmetic datapaths. It trades latency for area compared with the single-cycle combinational full adder cells.

## Interface
Parameters:
- WIDTH, 32, operand and sum width in bits; must be a multiple of SLICE.
- SLICE, 8, bits added per compute cycle; 1 ≤ SLICE ≤ WIDTH.
- NS (derived, not overridable): WIDTH/SLICE, the number of compute cycles.

Ports (clock is `clk`, reset is `rst_n`: asynchronous, active-low):
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ci  input  1  carry-in.
- sub  input  1  subtract mode; exists only when MCADD_SUB_EN is defined.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result, registered.
- co  output  1  carry-out, registered.

## Operation
- A WIDTH not divisible by SLICE is an elaboration error.
- FSM states and transitions:
  - IDLE → BUSY on in_valid & in_ready. The block captures a, b, ci (and sub) into internal registers and clears the slice counter k to 0.
  - BUSY, each edge: adds slice k, bits [k*SLICE +: SLICE], of A, B and the carry register. It writes that slice of the internal sum and updates the carry register. k increments each edge.
  - BUSY → DONE on the edge that processes k = NS-1. On that edge sum and co load the completed result.
  - DONE → IDLE on out_valid & out_ready.
- Slices are processed LSB first. Carry into slice 0 is the captured ci. co is the carry out of slice NS-1.
- Arithmetic is modulo 2^WIDTH; the overflow bit is reported only through co.
- in_valid in BUSY or DONE is ignored (in_ready = 0). The source must hold its operands until the handshake.
- sum and co change only on DONE entry and on reset. They hold their last value through IDLE, BUSY and backpressure.
- Reset mid-operation: the FSM returns to IDLE immediately (asynchronously). The in-flight operation is discarded and all outputs take their reset values.

## Timing
- Reset values: in_ready = 1 (IDLE), out_valid = 0, sum = 0, co = 0, carry register = 0, k = 0.
- in_ready = (state == IDLE). out_valid = (state == DONE). Both are decoded from registered state, with no combinational path from the inputs.
- Latency: out_valid rises NS clock edges after the accepting edge.
  - Defaults (NS = 4): accept at edge E0, out_valid high after E4.
  - SLICE = WIDTH (NS = 1): out_valid high after E1.
- There is no bypass. After the output handshake edge, in_ready is high on the next cycle.
- Minimum initiation interval is NS + 2 cycles: 1 accept, NS compute, 1 output handshake, assuming out_ready is already high.
- Backpressure: DONE holds indefinitely while out_ready = 0. out_valid, sum and co stay stable.

## Configuration
- MCADD_SUB_EN defined:
  - The `sub` port exists and is captured together with the operands.
  - sub = 1 computes a - b - borrow_in, implemented as a + ~b + ~ci. co is the raw carry: co = 1 means no borrow.
  - sub = 0 behaves as plain addition.
- MCADD_SUB_EN undefined: no `sub` port, addition only, and no operand inversion logic.

## Test plan
- Carry ripple across all slices: WIDTH = 32, SLICE = 8, a = 0xFFFFFFFF, b = 0, ci = 1, out_ready = 1 → out_valid after 4 edges, sum = 0x00000000, co = 1.
- Mixed values: a = 0x12345678, b = 0x0FEDCBA8, ci = 0 → sum = 0x22222220, co = 0. in_ready stays 0 from the accept edge until the cycle after the output handshake.
- Backpressure plus ignored input: hold out_ready = 0 for 10 cycles after out_valid, and pulse in_valid with new operands during that time → out_valid, sum and co stay stable, and the new operands are not accepted.
- Reset mid-BUSY: assert rst_n = 0 two cycles after accept → in_ready = 1, out_valid = 0, sum = 0, co = 0 immediately. A new operation after reset completes correctly.
- Subtract (MCADD_SUB_EN): a = 5, b = 7, ci = 0, sub = 1 → sum = 0xFFFFFFFE, co = 0. Then a = 7, b = 5 → sum = 2, co = 1.
- Degenerate slicing: WIDTH = 8, SLICE = 8, a = 0x80, b = 0x80, ci = 1 → out_valid after 1 edge, sum = 0x01, co = 1.
